// File: rtl/soft_forward_engine.sv
// -----------------------------------------------------------------------------
// soft_forward_engine
// Forward (alpha) recursion engine for the IDS soft decoder. One start pulse
// runs every step t = 1..N_len. Each step computes NUM_STATES*ND alpha cells,
// one per cycle, from the previous row held in a ping-pong bank and the gamma
// slices supplied for the current (t, d). Results stream out on a valid/ready
// port. Rows whose maximum falls below 2^(FRAC-NORM_SHIFT) are scaled up by
// 2^NORM_SHIFT for the next step, and the scale exponent is reported with
// every cell.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   start, n_len        run request and strand length (clamped to 1..N_MAX)
//   g_t, g_d            step / drift index whose gammas must be on gamma*_in
//   gamma0_in/1_in      ND packed W-bit gammas (slice k = d' index), b=0 / b=1
//   out_valid/ready     cell stream handshake
//   out_t/s/d/data/exp  cell coordinates, alpha value, scale exponent
//   busy, done          run in progress, one-cycle completion pulse
// -----------------------------------------------------------------------------
module soft_forward_engine #(
   parameter  int W          = 32,
   parameter  int FRAC       = 24,
   parameter  int N_MAX      = 10,
   parameter  int D_MAX      = 10,
   parameter  int NORM_SHIFT = 8,
   parameter  int EXP_W      = 8,
   localparam int NS         = 2*N_MAX+1,
   localparam int ND         = 2*D_MAX+1,
   localparam int TW         = $clog2(N_MAX+1),
   localparam int SW         = $clog2(NS),
   localparam int DW         = $clog2(ND)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [TW-1:0]    n_len,
   output logic [TW-1:0]    g_t,
   output logic [DW-1:0]    g_d,
   input  logic [ND*W-1:0]  gamma0_in,
   input  logic [ND*W-1:0]  gamma1_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [TW-1:0]    out_t,
   output logic [SW-1:0]    out_s,
   output logic [DW-1:0]    out_d,
   output logic [W-1:0]     out_data,
   output logic [EXP_W-1:0] out_exp,
   output logic             busy,
   output logic             done
);
   localparam int           AW       = W + $clog2(2*ND);
   localparam logic [W-1:0] ONE      = W'(1) << FRAC;
   localparam logic [W-1:0] NORM_LIM = W'(1) << (FRAC-NORM_SHIFT);

   typedef enum logic [2:0] {ST_IDLE, ST_INIT, ST_CALC, ST_HOLD, ST_SWAP, ST_FIN} state_t;

   state_t           r_state, w_next;
   logic [W-1:0]     r_bank [0:1][0:NS-1][0:ND-1];
   logic             r_sel;          // index of the prev bank
   logic             r_norm;         // prev row is read shifted by NORM_SHIFT
   logic             r_drain;        // last cell of the row issued, awaiting accept
   logic [TW-1:0]    r_t, r_nlen, w_nlen;
   logic [SW-1:0]    r_s, w_s1;
   logic [DW-1:0]    r_d;
   logic [EXP_W-1:0] r_exp;
   logic [W-1:0]     r_rowmax;
   logic             r_out_valid, r_busy, r_done;
   logic [TW-1:0]    r_out_t;
   logic [SW-1:0]    r_out_s;
   logic [DW-1:0]    r_out_d;
   logic [W-1:0]     r_out_data, w_cell;
   logic [EXP_W-1:0] r_out_exp;
   logic [AW-1:0]    w_acc;
   logic             w_go, w_fire, w_norm_next;
   int               w_s1_i;

   // Fixed-point multiply: keep bits [FRAC+W-1:FRAC], saturate on overflow
   function automatic logic [W-1:0] fp_m(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [2*W-1:0] p;
      p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      if (|p[2*W-1:FRAC+W]) fp_m = '1;
      else                  fp_m = p[FRAC+W-1:FRAC];
   endfunction

   // Optional renormalising left shift of a prev-bank operand, saturating
   function automatic logic [W-1:0] p_shift(input logic [W-1:0] x, input logic en);
      logic [W+NORM_SHIFT-1:0] wide;
      wide = {x, {NORM_SHIFT{1'b0}}};
      if (!en)                          p_shift = x;
      else if (|wide[W+NORM_SHIFT-1:W]) p_shift = '1;
      else                              p_shift = wide[W-1:0];
   endfunction

   assign g_t       = r_t;
   assign g_d       = r_d;
   assign out_valid = r_out_valid;
   assign out_t     = r_out_t;
   assign out_s     = r_out_s;
   assign out_d     = r_out_d;
   assign out_data  = r_out_data;
   assign out_exp   = r_out_exp;
   assign busy      = r_busy;
   assign done      = r_done;

   // A new cell may be produced when the output register is free or being taken
   assign w_go        = !r_out_valid || out_ready;
   assign w_fire      = ((r_state == ST_CALC) || (r_state == ST_HOLD)) && !r_drain && w_go;
   assign w_norm_next = (r_rowmax != '0) && (r_rowmax < NORM_LIM);

   // Strand length clamp to the supported range
   always_comb begin
      if (n_len == '0)                w_nlen = TW'(1);
      else if (n_len > TW'(N_MAX))    w_nlen = TW'(N_MAX);
      else                            w_nlen = n_len;
   end

   // Predecessor state of the b=1 branch: (s - t mod NS) mod NS
   always_comb begin
      w_s1_i = int'(r_s) + NS - (int'(r_t) % NS);
      if (w_s1_i >= NS) w_s1 = SW'(w_s1_i - NS);
      else              w_s1 = SW'(w_s1_i);
   end

   // Sum over all predecessor drifts for the current cell, saturated to W bits
   always_comb begin
      w_acc = '0;
      for (int k = 0; k < ND; k++) begin
         w_acc = w_acc
               + AW'(fp_m(gamma0_in[k*W +: W], p_shift(r_bank[r_sel][r_s][DW'(k)], r_norm)))
               + AW'(fp_m(gamma1_in[k*W +: W], p_shift(r_bank[r_sel][w_s1][DW'(k)], r_norm)));
      end
      if (|w_acc[AW-1:W]) w_cell = '1;
      else                w_cell = w_acc[W-1:0];
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (start) w_next = ST_INIT;
            else       w_next = ST_IDLE;
         end
         ST_INIT: w_next = ST_CALC;
         ST_CALC, ST_HOLD: begin
            if (!w_go)        w_next = ST_HOLD;
            else if (r_drain) w_next = ST_SWAP;
            else              w_next = ST_CALC;
         end
         ST_SWAP: begin
            if (r_t == r_nlen) w_next = ST_FIN;
            else               w_next = ST_CALC;
         end
         ST_FIN:  w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_next;
   end

   // Ping-pong alpha storage: INIT seeds the prev bank, CALC fills the cur bank
   always_ff @(posedge clk) begin
      if (!rst && (r_state == ST_INIT)) begin
         for (int s = 0; s < NS; s++) begin
            for (int d = 0; d < ND; d++) begin
               r_bank[r_sel][SW'(s)][DW'(d)] <= '0;
            end
         end
         r_bank[r_sel][SW'(0)][DW'(D_MAX)] <= ONE;
      end else if (!rst && w_fire) begin
         r_bank[~r_sel][r_s][r_d] <= w_cell;
      end
   end

   // Sequencing counters, row statistics and registered output port
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sel       <= 1'b0;
         r_norm      <= 1'b0;
         r_drain     <= 1'b0;
         r_t         <= '0;
         r_nlen      <= '0;
         r_s         <= '0;
         r_d         <= '0;
         r_exp       <= '0;
         r_rowmax    <= '0;
         r_out_valid <= 1'b0;
         r_out_t     <= '0;
         r_out_s     <= '0;
         r_out_d     <= '0;
         r_out_data  <= '0;
         r_out_exp   <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_nlen <= w_nlen;
                  r_busy <= 1'b1;
               end
            end
            ST_INIT: begin
               r_t      <= TW'(1);
               r_s      <= '0;
               r_d      <= '0;
               r_exp    <= '0;
               r_norm   <= 1'b0;
               r_drain  <= 1'b0;
               r_rowmax <= '0;
            end
            ST_CALC, ST_HOLD: begin
               if (w_go && r_drain) begin
                  r_out_valid <= 1'b0;
               end else if (w_fire) begin
                  r_out_valid <= 1'b1;
                  r_out_t     <= r_t;
                  r_out_s     <= r_s;
                  r_out_d     <= r_d;
                  r_out_data  <= w_cell;
                  r_out_exp   <= r_exp;
                  if (w_cell > r_rowmax) r_rowmax <= w_cell;
                  if (r_d == DW'(ND-1)) begin
                     r_d <= '0;
                     if (r_s == SW'(NS-1)) begin
                        r_s     <= '0;
                        r_drain <= 1'b1;
                     end else begin
                        r_s <= r_s + SW'(1);
                     end
                  end else begin
                     r_d <= r_d + DW'(1);
                  end
               end
            end
            ST_SWAP: begin
               r_sel    <= ~r_sel;
               r_norm   <= w_norm_next;
               r_rowmax <= '0;
               r_drain  <= 1'b0;
               r_s      <= '0;
               r_d      <= '0;
               if (w_norm_next && (r_exp != {EXP_W{1'b1}})) r_exp <= r_exp + EXP_W'(1);
               if (r_t == r_nlen) r_done <= 1'b1;
               else               r_t    <= r_t + TW'(1);
            end
            ST_FIN: begin
               r_done <= 1'b0;
               r_busy <= 1'b0;
            end
            default: begin
               r_done <= 1'b0;
            end
         endcase
      end
   end

endmodule
